// File: rtl/mem_responder_pkg.sv
// Shared constants and address-check helper for the multi-cycle memory responder.
package mem_responder_pkg;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int WORD_SHIFT = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // An address is bad if it is not word aligned or reaches past the last entry.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int idx_w);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[WORD_SHIFT-1:0] != '0);
        out_of_range = ((addr >> (idx_w + WORD_SHIFT)) != '0);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Unified instruction/data storage: synchronous write port, combinational read port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
    end

    assign rdata = mem_q[index];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory target with valid/ready request and response channels,
// programmable wait states and misaligned/out-of-range error reporting.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              req_err;
    logic              access;
    logic              acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_err = addr_error(req_addr, IDX_W);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        access     = 1'b0;
        acc_write  = write_q;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        acc_err    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    cnt_d   = LAT;
                    // With no wait states the access uses the live request directly.
                    if (LAT == 4'd0) begin
                        access    = 1'b1;
                        acc_write = req_write;
                        acc_idx   = req_addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
                        acc_wdata = req_wdata;
                        acc_err   = req_err;
                        state_d   = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    access  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (access) begin
            rdata_d    = (acc_write || acc_err) ? '0 : mem_rdata;
            resp_err_d = acc_err;
        end
    end

    // A reset landing on the commit edge must discard the store.
    assign mem_we = access & acc_write & ~acc_err & ~reset;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .index (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with LATENCY=2 (index 0)
// and one with LATENCY=0 (index 1), sharing clock and reset.
module tb_mem_responder;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_v  [2];
    logic        req_write_v  [2];
    logic [63:0] req_addr_v   [2];
    logic [63:0] req_wdata_v  [2];
    logic        resp_ready_v [2];

    logic        req_ready_a, resp_valid_a, resp_err_a, busy_a;
    logic [63:0] resp_rdata_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
    logic [63:0] resp_rdata_b;

    exp_t        sb [$];
    logic [63:0] model [int];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .LATENCY(2)) dut_lat2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_v[0]),
        .req_ready  (req_ready_a),
        .req_write  (req_write_v[0]),
        .req_addr   (req_addr_v[0]),
        .req_wdata  (req_wdata_v[0]),
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready_v[0]),
        .resp_rdata (resp_rdata_a),
        .resp_err   (resp_err_a),
        .busy       (busy_a)
    );

    mem_responder #(.DEPTH(256), .LATENCY(0)) dut_lat0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_v[1]),
        .req_ready  (req_ready_b),
        .req_write  (req_write_v[1]),
        .req_addr   (req_addr_v[1]),
        .req_wdata  (req_wdata_v[1]),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_v[1]),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b),
        .busy       (busy_b)
    );

    function automatic logic rr(input int w);
        return (w == 0) ? req_ready_a : req_ready_b;
    endfunction

    function automatic logic rv(input int w);
        return (w == 0) ? resp_valid_a : resp_valid_b;
    endfunction

    function automatic logic bz(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [63:0] rd(input int w);
        return (w == 0) ? resp_rdata_a : resp_rdata_b;
    endfunction

    function automatic logic re(input int w);
        return (w == 0) ? resp_err_a : resp_err_b;
    endfunction

    function automatic logic model_err(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a >= 64'd1024);
    endfunction

    function automatic int model_key(input int w, input logic [63:0] a);
        return w * 4096 + int'(a[11:2]);
    endfunction

    // Present one request in IDLE and record what the response must be.
    task automatic send_req(input int w, input logic wr, input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        int   k;
        @(negedge clk);
        checks++;
        if (rr(w) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_ready_before_req[%0d]: got %b expected 1", w, rr(w));
        end
        req_valid_v[w] = 1'b1;
        req_write_v[w] = wr;
        req_addr_v[w]  = a;
        req_wdata_v[w] = d;
        @(posedge clk);
        k     = model_key(w, a);
        e.err = model_err(a);
        if (e.err || wr) begin
            e.rdata = 64'd0;
        end else if (model.exists(k)) begin
            e.rdata = model[k];
        end else begin
            e.rdata = 64'hx;
        end
        if (wr && !e.err) begin
            model[k] = d;
        end
        sb.push_back(e);
        #1;
        req_valid_v[w] = 1'b0;
    endtask

    // Wait (bounded) for the response, check latency and data, then consume it.
    task automatic collect_resp(input int w, input int lat);
        int   cycles;
        exp_t e;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!rv(w) && cycles < 64);
        checks++;
        if (rv(w) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resp_timeout[%0d]: got no resp_valid after %0d cycles", w, cycles);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (cycles != lat + 1) begin
            errors++;
            $display("[TB] FAIL resp_latency[%0d]: got %0d cycles expected %0d", w, cycles, lat + 1);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty[%0d]: got response with nothing expected", w);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rd(w) !== e.rdata) begin
                errors++;
                $display("[TB] FAIL resp_rdata[%0d]: got %h expected %h", w, rd(w), e.rdata);
            end
            checks++;
            if (re(w) !== e.err) begin
                errors++;
                $display("[TB] FAIL resp_err[%0d]: got %b expected %b", w, re(w), e.err);
            end
        end
        resp_ready_v[w] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_v[w] = 1'b0;
        @(negedge clk);
        checks++;
        if (rr(w) !== 1'b1 || rv(w) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_consume[%0d]: got ready=%b valid=%b expected ready=1 valid=0", w, rr(w), rv(w));
        end
    endtask

    task automatic txn(input int w, input logic wr, input logic [63:0] a, input logic [63:0] d);
        send_req(w, wr, a, d);
        collect_resp(w, (w == 0) ? 2 : 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (rr(w) !== 1'b1 || rv(w) !== 1'b0 || bz(w) !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_idle[%0d]: got ready=%b valid=%b busy=%b expected 1 0 0", w, rr(w), rv(w), bz(w));
                end
            end
        end
    endtask

    task automatic test_store_load();
        txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
        txn(0, 1'b0, 64'h10, 64'h0);
    endtask

    task automatic test_distinct_words();
        txn(0, 1'b1, 64'h0, 64'h1111);
        txn(0, 1'b1, 64'h4, 64'h2222);
        txn(0, 1'b0, 64'h0, 64'h0);
        txn(0, 1'b0, 64'h4, 64'h0);
    endtask

    task automatic test_errors();
        txn(0, 1'b1, 64'h6, 64'hBAD0_0006);
        txn(0, 1'b1, 64'h400, 64'hBAD0_0400);
        txn(0, 1'b0, 64'h4, 64'h0);
        txn(0, 1'b0, 64'h7, 64'h0);
        txn(0, 1'b1, 64'h3FC, 64'h0123_4567_89AB_CDEF);
        txn(0, 1'b0, 64'h3FC, 64'h0);
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        exp_t        e;
        int          cycles;
        send_req(0, 1'b0, 64'h10, 64'h0);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!rv(0) && cycles < 64);
        held = rd(0);
        req_valid_v[0] = 1'b1;
        req_write_v[0] = 1'b1;
        req_addr_v[0]  = 64'h10;
        req_wdata_v[0] = 64'h0BAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rv(0) !== 1'b1 || rd(0) !== held || rr(0) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_resp cycle %0d: got valid=%b rdata=%h ready=%b expected 1 %h 0", i, rv(0), rd(0), rr(0), held);
            end
        end
        e = sb.pop_front();
        checks++;
        if (held !== e.rdata) begin
            errors++;
            $display("[TB] FAIL hold_rdata: got %h expected %h", held, e.rdata);
        end
        resp_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_v[0] = 1'b0;
        req_valid_v[0]  = 1'b0;
        @(negedge clk);
        checks++;
        if (rr(0) !== 1'b1 || rv(0) !== 1'b0 || bz(0) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_resp: got ready=%b valid=%b busy=%b expected 1 0 0", rr(0), rv(0), bz(0));
        end
        txn(0, 1'b0, 64'h10, 64'h0);
    endtask

    task automatic test_reset_mid_wait();
        txn(0, 1'b1, 64'h20, 64'h77);
        @(negedge clk);
        req_valid_v[0] = 1'b1;
        req_write_v[0] = 1'b1;
        req_addr_v[0]  = 64'h20;
        req_wdata_v[0] = 64'h55;
        @(posedge clk);
        #1;
        req_valid_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rv(0) !== 1'b0 || bz(0) !== 1'b0 || rr(0) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_wait cycle %0d: got valid=%b busy=%b ready=%b expected 0 0 1", i, rv(0), bz(0), rr(0));
            end
        end
        txn(0, 1'b0, 64'h20, 64'h0);
    endtask

    task automatic test_latency0();
        txn(1, 1'b1, 64'h20, 64'h55);
        txn(1, 1'b0, 64'h20, 64'h0);
        txn(1, 1'b1, 64'h40, 64'hABCD);
        txn(1, 1'b1, 64'h44, 64'h5A5A);
        send_req(1, 1'b1, 64'h40, 64'hFEED_0040);
        @(negedge clk);
        checks++;
        if (rv(1) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lat0_resp_valid: got %b expected 1", rv(1));
        end
        void'(sb.pop_front());
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rv(1) !== 1'b0 || bz(1) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp: got valid=%b busy=%b expected 0 0", rv(1), bz(1));
        end
        txn(1, 1'b0, 64'h40, 64'h0);
        txn(1, 1'b0, 64'h44, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        for (int w = 0; w < 2; w++) begin
            req_valid_v[w]  = 1'b0;
            req_write_v[w]  = 1'b0;
            req_addr_v[w]   = 64'd0;
            req_wdata_v[w]  = 64'd0;
            resp_ready_v[w] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_distinct_words();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_latency0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle memory target that services load, store and instruction-fetch requests issued by the datapath over its address/write-data/read-data interface.
- Sits between the multi-cycle controller/datapath and the unified instruction/data storage.
- Adds a valid/ready request channel, a valid/ready response channel, a programmable wait-state latency and error reporting.
- Holds one outstanding transaction at a time.

Parameters:
- DEPTH, 256: number of 64-bit storage entries; power of two, at least 2.
- LATENCY, 2: wait cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load/fetch
- req_addr  input  64  byte address
- req_wdata  input  64  store data
- resp_valid  output  1  response present
- resp_ready  input  1  requester consumes the response
- resp_rdata  output  64  load data; 0 for stores and for errors
- resp_err  output  1  misaligned or out-of-range access
- busy  output  1  transaction in flight (state is not IDLE)

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0.
- Reset does not clear storage contents.

Addressing:
- Each 4-byte-aligned address maps to its own 64-bit entry: index = req_addr[log2(DEPTH)+1:2]. PC+4 therefore reaches the next entry.
- Misaligned: req_addr[1:0] != 0.
- Out of range: req_addr[63:log2(DEPTH)+2] != 0.
- Either condition gives resp_err=1 and resp_rdata=0. A store with an error does not modify storage.

State machine (IDLE, WAIT, RESP):
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, addr, wdata and error flag; load counter with LATENCY.
  - If LATENCY=0, go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter reaches 1 it performs the access and goes to RESP.
- Access at the WAIT→RESP edge (or at the IDLE→RESP edge when LATENCY=0):
  - Load: capture storage[index] into resp_rdata.
  - Store: commit to storage; resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until consumed.
  - On resp_ready, go to IDLE; resp_valid=0 and req_ready=1 from the next cycle.
  - No back-to-back acceptance in the consume cycle.
- Latency: request accepted at edge T → resp_valid high from cycle T+1+LATENCY.
- req_* inputs are ignored outside IDLE; the requester holds them until req_ready.
- A load from the same index immediately after a store returns the new data.
- Reset mid-WAIT: transaction discarded and store not committed.
- Reset mid-RESP: response dropped; an already-committed store persists.
- resp_ready while resp_valid=0 has no effect.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - ADDR_W=64, DATA_W=64, WORD_SHIFT=2
- One sub-module, mem_array: DEPTH×64 storage with a synchronous write port (we, index, wdata) and a combinational read port (index → rdata).
- The FSM, counter, error check and response registers live in mem_responder.

Test Plan:
1. Reset, then idle for 5 cycles → req_ready=1, resp_valid=0, busy=0 throughout.
2. LATENCY=2: store addr 0x10, data 0xDEADBEEF_CAFEF00D accepted at edge T → resp_valid at T+3 with resp_err=0, resp_rdata=0. Then load addr 0x10 → resp_rdata=0xDEADBEEF_CAFEF00D.
3. Addresses 0x0 and 0x4 hold distinct values 0x1111 and 0x2222 → loads return each value independently.
4. Store to 0x6 (misaligned), then store to 0x400 with DEPTH=256 (out of range) → resp_err=1 for both. A subsequent load of 0x4 still returns 0x2222.
5. Hold resp_ready=0 for 4 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored. Raise resp_ready → req_ready=1 the next cycle.
6. Store 0x55 to 0x20; assert reset during WAIT → no response, and a later load of 0x20 returns the old value. Repeat with LATENCY=0 → resp_valid one cycle after acceptance.
